// File: rtl/imm_decode_ctrl.sv
// Decode-stage front end for the sext immediate generator: 2-entry skid buffer
// on a valid/ready handshake, presenting the head word with registered decode.
module imm_decode_ctrl #(
  parameter logic [31:0] NOP_IR      = 32'h0000_0013,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid,
  input  logic [31:0]            if_ir,
  output logic                   if_ready,
  input  logic                   flush,
  input  logic                   id_ready,
  output logic                   ir2_valid,
  output logic [31:0]            ir2,
  output logic [2:0]             sext_select,
  output logic                   has_imm,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned IR_W  = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_I = 3'd0;
  localparam logic [SEL_W-1:0] SEL_B = 3'd1;
  localparam logic [SEL_W-1:0] SEL_U = 3'd2;
  localparam logic [SEL_W-1:0] SEL_S = 3'd3;
  localparam logic [SEL_W-1:0] SEL_J = 3'd4;

  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             has_imm;
    logic             illegal;
  } dec_t;

  // Immediate-format decode of a RISC-V major opcode.
  function automatic dec_t decode(input logic [OPC_W-1:0] opc);
    dec_t d;
    d.sel     = SEL_I;
    d.has_imm = 1'b1;
    d.illegal = 1'b0;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: d.sel = SEL_I;
      OPC_BRANCH:                                 d.sel = SEL_B;
      OPC_LUI, OPC_AUIPC:                         d.sel = SEL_U;
      OPC_STORE:                                  d.sel = SEL_S;
      OPC_JAL:                                    d.sel = SEL_J;
      OPC_OP, OPC_FENCE:                          d.has_imm = 1'b0;
      default: begin
        d.has_imm = 1'b0;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  state_e                 state_q, state_d;
  logic [IR_W-1:0]        skid_q, skid_d;
  logic                   if_ready_q, if_ready_d;
  logic                   ir2_valid_q, ir2_valid_d;
  logic [IR_W-1:0]        ir2_q, ir2_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   has_imm_q, has_imm_d;
  logic                   illegal_q, illegal_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic                   accept;
  logic                   pop;
  logic [IR_W-1:0]        head_d;
  dec_t                   dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      skid_q      <= NOP_IR;
      if_ready_q  <= 1'b1;
      ir2_valid_q <= 1'b0;
      ir2_q       <= NOP_IR;
      sel_q       <= SEL_I;
      has_imm_q   <= 1'b1;
      illegal_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      skid_q      <= skid_d;
      if_ready_q  <= if_ready_d;
      ir2_valid_q <= ir2_valid_d;
      ir2_q       <= ir2_d;
      sel_q       <= sel_d;
      has_imm_q   <= has_imm_d;
      illegal_q   <= illegal_d;
      stall_q     <= stall_d;
    end
  end

  // Next-state, buffer movement and head decode; decode is taken from the
  // next head word so every output is a flop with no path from if_ir.
  always_comb begin
    state_d     = state_q;
    skid_d      = skid_q;
    head_d      = ir2_q;
    stall_d     = stall_q;
    ir2_valid_d = 1'b0;
    ir2_d       = NOP_IR;
    sel_d       = SEL_I;
    has_imm_d   = 1'b1;
    illegal_d   = 1'b0;
    if_ready_d  = 1'b1;
    dec         = decode(OPC_OP_IMM);

    accept = if_valid & if_ready_q;
    pop    = ir2_valid_q & id_ready;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_d  = if_ir;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_d = if_ir;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = if_ir;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    if (state_d != EMPTY) begin
      dec         = decode(head_d[OPC_W-1:0]);
      ir2_valid_d = 1'b1;
      ir2_d       = head_d;
      sel_d       = dec.sel;
      has_imm_d   = dec.has_imm;
      illegal_d   = dec.illegal;
    end
    if_ready_d = (state_d != TWO);

    // Saturating downstream-stall counter, unaffected by flush.
    if (ir2_valid_q && !id_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  assign if_ready     = if_ready_q;
  assign ir2_valid    = ir2_valid_q;
  assign ir2          = ir2_q;
  assign sext_select  = sel_q;
  assign has_imm      = has_imm_q;
  assign illegal      = illegal_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed self-checking bench for imm_decode_ctrl with a 4-bit stall counter.
module tb_imm_decode_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned SW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_valid;
  logic [31:0]   if_ir;
  logic          if_ready;
  logic          flush;
  logic          id_ready;
  logic          ir2_valid;
  logic [31:0]   ir2;
  logic [2:0]    sext_select;
  logic          has_imm;
  logic          illegal;
  logic [SW-1:0] stall_cycles;

  int passed = 0;
  int total  = 0;

  imm_decode_ctrl #(.NOP_IR(NOP), .STALL_CNT_W(SW)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ir(if_ir),
    .if_ready(if_ready), .flush(flush), .id_ready(id_ready),
    .ir2_valid(ir2_valid), .ir2(ir2), .sext_select(sext_select),
    .has_imm(has_imm), .illegal(illegal), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic rdy, input logic fl);
    if_valid = v;
    if_ir    = ir;
    id_ready = rdy;
    flush    = fl;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] w,
                            input logic [2:0] sel, input logic imm, input logic ill);
    check({tag, ".valid"},   32'(ir2_valid),   32'(v));
    check({tag, ".ir2"},     ir2,              w);
    check({tag, ".sel"},     32'(sext_select), 32'(sel));
    check({tag, ".has_imm"}, 32'(has_imm),     32'(imm));
    check({tag, ".illegal"}, 32'(illegal),     32'(ill));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    check_head("rst", 1'b0, NOP, 3'd0, 1'b1, 1'b0);
    check("rst.if_ready", 32'(if_ready), 32'd1);
    check("rst.stall", 32'(stall_cycles), 32'd0);
    reset = 1'b0;
    step();

    // Single addi from empty: visible next cycle
    drive(1'b1, 32'h0050_0093, 1'b1, 1'b0);
    step();
    check_head("t1", 1'b1, 32'h0050_0093, 3'd0, 1'b1, 1'b0);

    // Back-to-back B/U/S/J stream with downstream always ready
    drive(1'b1, 32'h0000_0463, 1'b1, 1'b0); step();
    check_head("t2b", 1'b1, 32'h0000_0463, 3'd1, 1'b1, 1'b0);
    check("t2b.if_ready", 32'(if_ready), 32'd1);
    drive(1'b1, 32'h0000_10B7, 1'b1, 1'b0); step();
    check_head("t2u", 1'b1, 32'h0000_10B7, 3'd2, 1'b1, 1'b0);
    check("t2u.if_ready", 32'(if_ready), 32'd1);
    drive(1'b1, 32'h0011_2023, 1'b1, 1'b0); step();
    check_head("t2s", 1'b1, 32'h0011_2023, 3'd3, 1'b1, 1'b0);
    check("t2s.if_ready", 32'(if_ready), 32'd1);
    drive(1'b1, 32'h0080_00EF, 1'b1, 1'b0); step();
    check_head("t2j", 1'b1, 32'h0080_00EF, 3'd4, 1'b1, 1'b0);
    check("t2j.if_ready", 32'(if_ready), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    check_head("t2e", 1'b0, NOP, 3'd0, 1'b1, 1'b0);
    check("t2e.stall", 32'(stall_cycles), 32'd0);

    // Downstream stall: two words fill the buffer, third is held off
    drive(1'b1, 32'h0010_0113, 1'b0, 1'b0); step();
    check("t3a.ir2", ir2, 32'h0010_0113);
    check("t3a.if_ready", 32'(if_ready), 32'd1);
    check("t3a.stall", 32'(stall_cycles), 32'd0);
    drive(1'b1, 32'h0020_0193, 1'b0, 1'b0); step();
    check("t3b.ir2", ir2, 32'h0010_0113);
    check("t3b.if_ready", 32'(if_ready), 32'd0);
    check("t3b.stall", 32'(stall_cycles), 32'd1);
    drive(1'b1, 32'h0030_0213, 1'b0, 1'b0); step();
    check("t3c.ir2", ir2, 32'h0010_0113);
    check("t3c.if_ready", 32'(if_ready), 32'd0);
    check("t3c.stall", 32'(stall_cycles), 32'd2);
    step();
    check("t3d.stall", 32'(stall_cycles), 32'd3);
    drive(1'b1, 32'h0030_0213, 1'b1, 1'b0); step();
    check_head("t3e", 1'b1, 32'h0020_0193, 3'd0, 1'b1, 1'b0);
    check("t3e.if_ready", 32'(if_ready), 32'd1);
    step();
    check_head("t3f", 1'b1, 32'h0030_0213, 3'd0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    check("t3g.valid", 32'(ir2_valid), 32'd0);
    check("t3g.stall", 32'(stall_cycles), 32'd3);

    // Flush from TWO while a new word is offered
    drive(1'b1, 32'h0040_0293, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0050_0313, 1'b0, 1'b0); step();
    check("t4a.if_ready", 32'(if_ready), 32'd0);
    check("t4a.stall", 32'(stall_cycles), 32'd4);
    drive(1'b1, 32'h0060_0393, 1'b1, 1'b1); step();
    check_head("t4b", 1'b0, NOP, 3'd0, 1'b1, 1'b0);
    check("t4b.if_ready", 32'(if_ready), 32'd1);
    check("t4b.stall", 32'(stall_cycles), 32'd4);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4c.valid", 32'(ir2_valid), 32'd0);
    end

    // Illegal opcode, then a register-register op with no immediate
    drive(1'b1, 32'h0000_007F, 1'b1, 1'b0); step();
    check_head("t5a", 1'b1, 32'h0000_007F, 3'd0, 1'b0, 1'b1);
    drive(1'b1, 32'h0020_8033, 1'b1, 1'b0); step();
    check_head("t5b", 1'b1, 32'h0020_8033, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    check_head("t5c", 1'b0, NOP, 3'd0, 1'b1, 1'b0);

    // Long stall saturates the counter, then async reset mid-stream
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0); step();
    check("t6a.stall", 32'(stall_cycles), 32'd4);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("t6b.stall", 32'(stall_cycles), 32'd15);
    check("t6b.valid", 32'(ir2_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_head("t6c", 1'b0, NOP, 3'd0, 1'b1, 1'b0);
    check("t6c.if_ready", 32'(if_ready), 32'd1);
    check("t6c.stall", 32'(stall_cycles), 32'd0);
    step();
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
